router_output_arbiter: RTL and testbench

- Per-output-port arbiter for the mesh router. Shares one output channel between the five input ports (local, N, E, S, W).
- Keeps a separate round-robin pointer for each virtual channel, selected by `polarity`.
- Forwards the winning 64-bit flit to the output channel's `data_in` and returns a one-hot grant to the requesters.
- Stalls entirely while the output channel reports `blocked`.

---
 rtl/noc_pkg.sv | 23 ++
 rtl/router_output_arbiter_if.sv | 32 +++
 rtl/router_rr_picker.sv | 41 ++++
 rtl/router_output_arbiter.sv | 87 ++++++++
 tb/tb_router_output_arbiter.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// Shared mesh-router definitions.
// Provides the flit width, the number of router ports with their index
// constants, the empty-flit value, and the small types used to carry port
// indices and flits between router blocks.
package noc_pkg;

  localparam int DATA_W    = 64;
  localparam int NUM_PORTS = 5;
  localparam int PTR_W     = 3;   // enough bits to index NUM_PORTS inputs

  localparam int PORT_LOCAL = 0;
  localparam int PORT_N     = 1;
  localparam int PORT_E     = 2;
  localparam int PORT_S     = 3;
  localparam int PORT_W     = 4;

  typedef logic [DATA_W-1:0] flit_t;
  typedef logic [PTR_W-1:0]  port_idx_t;

  // An all-zero flit means "no flit" everywhere in the router.
  localparam flit_t EMPTY_FLIT = '0;

endpackage

// File: rtl/router_output_arbiter_if.sv
// Request/grant channel between the router input ports and one output arbiter.
// Signals:
//   polarity  VC select (1 = VC1 being filled, 0 = VC2 being filled)
//   req       per-input request for this output
//   data_in   flattened head flits, input i at [i*DATA_W +: DATA_W]
//   blocked   output channel cannot accept data this cycle
//   grant     one-hot grant back to the inputs
//   data_out  flit forwarded to the output channel
//   busy      an eligible request was left waiting in the last arbitration
// Modports: master = input-port side (drives requests), slave = arbiter.
interface router_output_arbiter_if #(
  parameter int NUM_IN = noc_pkg::NUM_PORTS,
  parameter int DATA_W = noc_pkg::DATA_W
);
  logic                     polarity;
  logic [NUM_IN-1:0]        req;
  logic [NUM_IN*DATA_W-1:0] data_in;
  logic                     blocked;
  logic [NUM_IN-1:0]        grant;
  logic [DATA_W-1:0]        data_out;
  logic                     busy;

  modport master (
    output polarity, req, data_in, blocked,
    input  grant, data_out, busy
  );

  modport slave (
    input  polarity, req, data_in, blocked,
    output grant, data_out, busy
  );
endinterface

// File: rtl/router_rr_picker.sv
// Combinational round-robin picker.
// Scans req starting at index start, ascending, wrapping from NUM_IN-1 to 0,
// and reports the first set bit.
// Ports:
//   req    NUM_IN-wide request vector
//   start  index to begin the scan at (0..NUM_IN-1)
//   found  at least one request bit is set
//   idx    index of the winning request (0 when nothing found)
module router_rr_picker
  import noc_pkg::*;
#(
  parameter int NUM_IN = NUM_PORTS
) (
  input  logic [NUM_IN-1:0] req,
  input  port_idx_t         start,
  output logic              found,
  output port_idx_t         idx
);

  // One extra bit so start + offset cannot overflow before the wrap compare.
  logic [PTR_W:0] cand;

  // NOTE: every signal written here gets a default before the loop; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      cand = {1'b0, start} + (PTR_W+1)'(k);
      if (cand > (PTR_W+1)'(NUM_IN-1)) begin
        cand = cand - (PTR_W+1)'(NUM_IN);
      end
      if (!found && req[cand[PTR_W-1:0]]) begin
        found = 1'b1;
        idx   = cand[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/router_output_arbiter.sv
// Per-output-port arbiter for the mesh router.
// Shares one output channel between NUM_IN input ports using a round-robin
// pointer per virtual channel (chosen by polarity), forwards the winning flit
// and returns a registered one-hot grant. Everything stalls while blocked.
// Ports:
//   clk    clock
//   reset  synchronous, active-high reset
//   bus    request/grant channel (slave side): polarity, req, data_in,
//          blocked in; grant, data_out, busy out (all outputs registered)
module router_output_arbiter
  import noc_pkg::*;
#(
  parameter int NUM_IN = NUM_PORTS,
  parameter int DATA_W = noc_pkg::DATA_W
) (
  input  logic                    clk,
  input  logic                    reset,
  router_output_arbiter_if.slave  bus
);

  logic [NUM_IN-1:0] grant_q;
  logic [DATA_W-1:0] data_q;
  logic              busy_q;
  port_idx_t         ptr_vc1;
  port_idx_t         ptr_vc2;

  logic [NUM_IN-1:0] nonzero;
  logic [NUM_IN-1:0] ereq;
  logic [NUM_IN-1:0] win_onehot;
  logic [DATA_W-1:0] win_data;
  port_idx_t         start_ptr;
  port_idx_t         win_idx;
  port_idx_t         next_ptr;
  logic              found;

  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      nonzero[i] = (bus.data_in[i*DATA_W +: DATA_W] != EMPTY_FLIT);
    end
  end

  // The input granted last cycle pops its head on this edge; granting it
  // again now would send the same flit twice.
  assign ereq      = bus.req & nonzero & ~grant_q;
  assign start_ptr = bus.polarity ? ptr_vc1 : ptr_vc2;

  router_rr_picker #(.NUM_IN(NUM_IN)) u_picker (
    .req   (ereq),
    .start (start_ptr),
    .found (found),
    .idx   (win_idx)
  );

  assign win_onehot = found ? (NUM_IN'(1) << win_idx) : '0;
  assign win_data   = found ? bus.data_in[int'(win_idx)*DATA_W +: DATA_W] : EMPTY_FLIT;
  // Explicit wrap: NUM_IN is not a power of two.
  assign next_ptr   = (win_idx == port_idx_t'(NUM_IN-1)) ? '0 : win_idx + 1'b1;

  // NOTE: registered state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q <= '0;
      data_q  <= EMPTY_FLIT;
      busy_q  <= 1'b0;
      ptr_vc1 <= '0;
      ptr_vc2 <= '0;
    end else if (bus.blocked) begin
      grant_q <= '0;
      data_q  <= EMPTY_FLIT;
      busy_q  <= |(bus.req & nonzero);
    end else begin
      grant_q <= win_onehot;
      data_q  <= win_data;
      busy_q  <= |(ereq & ~win_onehot);
      if (found) begin
        if (bus.polarity) ptr_vc1 <= next_ptr;
        else              ptr_vc2 <= next_ptr;
      end
    end
  end

  assign bus.grant    = grant_q;
  assign bus.data_out = data_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_router_output_arbiter.sv
// Self-checking bench for router_output_arbiter: a table of directed
// vectors followed by randomized traffic checked against a reference model.
module tb_router_output_arbiter;
  import noc_pkg::*;

  localparam int N = 5;
  localparam int W = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  router_output_arbiter_if #(.NUM_IN(N), .DATA_W(W)) bus ();

  router_output_arbiter #(.NUM_IN(N), .DATA_W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Flit patterns: 0 all empty; 1 per-input byte with row tag (changes every
  // row, i.e. each granted input shows its next flit); 2 like 1 but input 4
  // empty; 3 constant per-input flit.
  function automatic logic [63:0] flit(input int pat, input int row, input int i);
    logic [7:0] b;
    b = 8'(17 * (i + 1));
    case (pat)
      1:       return {{7{b}}, 8'(row + 1)};
      2:       return (i == 4) ? 64'h0 : {{7{b}}, 8'(row + 1)};
      3:       return {8{b}};
      default: return 64'h0;
    endcase
  endfunction

  typedef struct {
    logic       rst;
    logic       pol;
    logic [4:0] req;
    logic       blk;
    int         pat;
    logic [4:0] eg;
    logic       eb;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic pol, input logic [4:0] req,
                              input logic blk, input int pat, input logic [4:0] eg,
                              input logic eb);
    vec_t v;
    v.rst = rst; v.pol = pol; v.req = req; v.blk = blk;
    v.pat = pat; v.eg = eg; v.eb = eb;
    return v;
  endfunction

  vec_t tbl[30];

  // Reference model state: one pointer per VC (index = polarity) and the
  // input granted in the previous cycle (-1 when none).
  int m_ptr[2];
  int m_last;
  logic [63:0] d[N];

  task automatic model_step(input logic rst, input logic pol, input logic blk,
                            input logic [4:0] rq, output logic [4:0] eg,
                            output logic [63:0] ed, output logic eb);
    int w;
    int p;
    eg = '0; ed = '0; eb = 1'b0;
    p = pol ? 1 : 0;
    if (rst) begin
      m_ptr[0] = 0; m_ptr[1] = 0; m_last = -1;
    end else if (blk) begin
      for (int i = 0; i < N; i++) if (rq[i] && d[i] != 0) eb = 1'b1;
      m_last = -1;
    end else begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr[p] + k) % N;
        if (w < 0 && rq[i] && d[i] != 0 && i != m_last) w = i;
      end
      for (int i = 0; i < N; i++)
        if (i != w && rq[i] && d[i] != 0 && i != m_last) eb = 1'b1;
      if (w >= 0) begin
        eg[w]    = 1'b1;
        ed       = d[w];
        m_ptr[p] = (w + 1) % N;
      end
      m_last = w;
    end
  endtask

  initial begin
    logic [4:0]  eg;
    logic [63:0] ed;
    logic        eb;
    logic        r_rst, r_pol, r_blk;
    logic [4:0]  r_req;

    reset        = 1'b1;
    bus.polarity = 1'b1;
    bus.req      = '0;
    bus.blocked  = 1'b0;
    bus.data_in  = '0;

    // Reset, VC1 fairness, independent VC pointers, blocked stall,
    // zero-flit and no-duplicate rules, wrap with mid-operation reset.
    tbl[0]  = mk(1, 1, 5'b11111, 0, 1, 5'b00000, 0);
    tbl[1]  = mk(1, 1, 5'b11111, 0, 1, 5'b00000, 0);
    tbl[2]  = mk(0, 1, 5'b11111, 0, 1, 5'b00001, 1);
    tbl[3]  = mk(0, 1, 5'b11111, 0, 1, 5'b00010, 1);
    tbl[4]  = mk(0, 1, 5'b11111, 0, 1, 5'b00100, 1);
    tbl[5]  = mk(0, 1, 5'b11111, 0, 1, 5'b01000, 1);
    tbl[6]  = mk(0, 1, 5'b11111, 0, 1, 5'b10000, 1);
    tbl[7]  = mk(0, 1, 5'b11111, 0, 1, 5'b00001, 1);
    tbl[8]  = mk(0, 1, 5'b00100, 0, 1, 5'b00100, 0);
    tbl[9]  = mk(0, 0, 5'b11111, 0, 1, 5'b00001, 1);
    tbl[10] = mk(0, 1, 5'b11111, 0, 1, 5'b01000, 1);
    tbl[11] = mk(0, 1, 5'b00110, 1, 1, 5'b00000, 1);
    tbl[12] = mk(0, 1, 5'b00110, 1, 1, 5'b00000, 1);
    tbl[13] = mk(0, 1, 5'b00110, 1, 1, 5'b00000, 1);
    tbl[14] = mk(0, 1, 5'b00110, 0, 1, 5'b00010, 1);
    tbl[15] = mk(0, 1, 5'b10000, 0, 2, 5'b00000, 0);
    tbl[16] = mk(0, 1, 5'b10000, 1, 2, 5'b00000, 0);
    tbl[17] = mk(0, 1, 5'b10000, 0, 2, 5'b00000, 0);
    tbl[18] = mk(0, 1, 5'b00010, 0, 3, 5'b00010, 0);
    tbl[19] = mk(0, 1, 5'b00010, 0, 3, 5'b00000, 0);
    tbl[20] = mk(0, 1, 5'b00010, 0, 3, 5'b00010, 0);
    tbl[21] = mk(0, 1, 5'b00010, 0, 3, 5'b00000, 0);
    tbl[22] = mk(0, 1, 5'b00100, 0, 1, 5'b00100, 0);
    tbl[23] = mk(0, 1, 5'b01000, 0, 1, 5'b01000, 0);
    tbl[24] = mk(0, 1, 5'b10001, 0, 1, 5'b10000, 1);
    tbl[25] = mk(0, 1, 5'b10001, 0, 1, 5'b00001, 0);
    tbl[26] = mk(1, 1, 5'b10001, 0, 1, 5'b00000, 0);
    tbl[27] = mk(0, 0, 5'b11111, 0, 1, 5'b00001, 1);
    tbl[28] = mk(0, 0, 5'b00000, 0, 1, 5'b00000, 0);
    tbl[29] = mk(0, 1, 5'b11111, 0, 1, 5'b00001, 1);

    for (int r = 0; r < 30; r++) begin
      reset        = tbl[r].rst;
      bus.polarity = tbl[r].pol;
      bus.req      = tbl[r].req;
      bus.blocked  = tbl[r].blk;
      for (int i = 0; i < N; i++) bus.data_in[i*W +: W] = flit(tbl[r].pat, r, i);
      ed = '0;
      for (int i = 0; i < N; i++) if (tbl[r].eg[i]) ed = flit(tbl[r].pat, r, i);
      @(posedge clk);
      #1;
      check($sformatf("tbl[%0d].grant", r),    64'(bus.grant), 64'(tbl[r].eg));
      check($sformatf("tbl[%0d].data_out", r), bus.data_out,   ed);
      check($sformatf("tbl[%0d].busy", r),     64'(bus.busy),  64'(tbl[r].eb));
    end

    // Randomized traffic against the reference model; starts from reset.
    m_ptr[0] = 0; m_ptr[1] = 0; m_last = -1;
    r_pol = 1'b1;
    for (int c = 0; c < 600; c++) begin
      r_rst = (c == 0) || ($urandom_range(0, 49) == 0);
      r_blk = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 3) == 0) r_pol = ~r_pol;
      r_req = 5'($urandom);
      for (int i = 0; i < N; i++)
        d[i] = ($urandom_range(0, 3) == 0) ? 64'h0 : {$urandom, $urandom};
      reset        = r_rst;
      bus.polarity = r_pol;
      bus.req      = r_req;
      bus.blocked  = r_blk;
      for (int i = 0; i < N; i++) bus.data_in[i*W +: W] = d[i];
      model_step(r_rst, r_pol, r_blk, r_req, eg, ed, eb);
      @(posedge clk);
      #1;
      check($sformatf("rand[%0d].grant", c),    64'(bus.grant), 64'(eg));
      check($sformatf("rand[%0d].data_out", c), bus.data_out,   ed);
      check($sformatf("rand[%0d].busy", c),     64'(bus.busy),  64'(eb));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
